// File: rtl/stride_pkg.sv
// Shared encodings for the stride counter family.
// The direction and mode encodings are common to every variant built on stride_next.
package stride_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage : stride_pkg

// File: rtl/stride_next.sv
// Combinational next-count logic: one stride step with wrap or saturate handling.
// Kept free of state so multi-channel variants can share it.
module stride_next
    import stride_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] step,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] next,
    output logic             wrap,
    output logic             sat
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] res;
    logic           ovf;

    // The extra top bit is the carry going up, or the borrow going down.
    assign sum  = {1'b0, cur} + {1'b0, step};
    assign diff = {1'b0, cur} - {1'b0, step};
    assign res  = (dir == DIR_UP) ? sum : diff;
    assign ovf  = res[WIDTH];

    always_comb begin
        next = res[WIDTH-1:0];
        wrap = 1'b0;
        sat  = 1'b0;
        if (ovf) begin
            if (mode == MODE_SAT) begin
                sat  = 1'b1;
                next = (dir == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            end else begin
                wrap = 1'b1;
            end
        end
    end

endmodule : stride_next

// File: rtl/stride_counter.sv
// Up/down counter with a runtime stride, wrap or saturate overflow, load and sticky flag.
// All outputs are registered; priority per edge is reset > load > enable > hold.
module stride_counter
    import stride_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int INIT  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o,
    output logic             sat_o,
    output logic             ovf_sticky_o
);

    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

    logic [WIDTH-1:0] step_next;
    logic             step_wrap;
    logic             step_sat;

    stride_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .cur (cnt_o),
        .step(step_i),
        .dir (dir_i),
        .mode(mode_i),
        .next(step_next),
        .wrap(step_wrap),
        .sat (step_sat)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_o        <= INIT_VAL;
            wrap_o       <= 1'b0;
            sat_o        <= 1'b0;
            ovf_sticky_o <= 1'b0;
        end else if (load_i) begin
            cnt_o        <= load_val_i;
            wrap_o       <= 1'b0;
            sat_o        <= 1'b0;
            ovf_sticky_o <= ovf_sticky_o & ~clr_ovf_i;
        end else if (en_i) begin
            cnt_o        <= step_next;
            wrap_o       <= step_wrap;
            sat_o        <= step_sat;
            // A fresh event beats a simultaneous clear.
            ovf_sticky_o <= step_wrap | step_sat | (ovf_sticky_o & ~clr_ovf_i);
        end else begin
            wrap_o       <= 1'b0;
            sat_o        <= 1'b0;
            ovf_sticky_o <= ovf_sticky_o & ~clr_ovf_i;
        end
    end

endmodule : stride_counter

// File: tb/tb_stride_counter.sv
// Directed and random checks of stride_counter (WIDTH=8, INIT=1) against a behavioural model.
module tb_stride_counter;

    localparam int W = 8;
    localparam int OW = W + 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en_i = 1'b0;
    logic         dir_i = 1'b0;
    logic         mode_i = 1'b0;
    logic [W-1:0] step_i = '0;
    logic         load_i = 1'b0;
    logic [W-1:0] load_val_i = '0;
    logic         clr_ovf_i = 1'b0;
    logic [W-1:0] cnt_o;
    logic         wrap_o;
    logic         sat_o;
    logic         ovf_sticky_o;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] exp_q[$];

    // Model state
    int   m_cnt = 1;
    logic m_sticky = 1'b0;

    stride_counter #(
        .WIDTH(W),
        .INIT (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (en_i),
        .dir_i       (dir_i),
        .mode_i      (mode_i),
        .step_i      (step_i),
        .load_i      (load_i),
        .load_val_i  (load_val_i),
        .clr_ovf_i   (clr_ovf_i),
        .cnt_o       (cnt_o),
        .wrap_o      (wrap_o),
        .sat_o       (sat_o),
        .ovf_sticky_o(ovf_sticky_o)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] observed();
        return {cnt_o, wrap_o, sat_o, ovf_sticky_o};
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed cnt=%0d w=%0b s=%0b st=%0b, expected cnt=%0d w=%0b s=%0b st=%0b",
                   tag, obs[OW-1:3], obs[2], obs[1], obs[0], expv[OW-1:3], expv[2], expv[1], expv[0]);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic do_cycle(input logic rst_n, input logic ld, input logic [W-1:0] lv,
                            input logic en, input logic dir, input logic mode,
                            input logic [W-1:0] stp, input logic clr, input string tag);
        int   r;
        logic w, s;
        logic [OW-1:0] expv;
        reset_n = rst_n; load_i = ld; load_val_i = lv; en_i = en;
        dir_i = dir; mode_i = mode; step_i = stp; clr_ovf_i = clr;
        w = 1'b0;
        s = 1'b0;
        if (!rst_n) begin
            m_cnt = 1;
            m_sticky = 1'b0;
        end else if (ld) begin
            m_cnt = int'(lv);
            m_sticky = m_sticky & ~clr;
        end else if (en) begin
            r = dir ? (m_cnt - int'(stp)) : (m_cnt + int'(stp));
            if (r > 255 || r < 0) begin
                if (mode) begin
                    s = 1'b1;
                    m_cnt = dir ? 0 : 255;
                end else begin
                    w = 1'b1;
                    m_cnt = r & 255;
                end
            end else begin
                m_cnt = r;
            end
            m_sticky = w | s | (m_sticky & ~clr);
        end else begin
            m_sticky = m_sticky & ~clr;
        end
        expv = {W'(m_cnt), w, s, m_sticky};
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        check(tag, observed(), exp_q.pop_front());
    endtask

    task automatic hold(input string tag);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        // Reset state
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, "reset");
        check("reset_const", observed(), {8'd1, 1'b0, 1'b0, 1'b0});

        // 1: up, wrap, step 2 through 255 and back to 1
        for (int i = 0; i < 128; i++) do_cycle(1, 0, 0, 1, 0, 0, 8'd2, 0, "up_wrap_seq");
        check("up_wrap_end", observed(), {8'd1, 1'b1, 1'b0, 1'b1});
        hold("up_wrap_pulse_clear");
        check("wrap_one_cycle", observed(), {8'd1, 1'b0, 1'b0, 1'b1});

        // 2: saturate up from 250
        do_cycle(1, 1, 8'd250, 0, 0, 1, 0, 1, "load250_clr");
        do_cycle(1, 0, 0, 1, 0, 1, 8'd4, 0, "sat_up_254");
        check("sat_254", observed(), {8'd254, 1'b0, 1'b0, 1'b0});
        do_cycle(1, 0, 0, 1, 0, 1, 8'd4, 0, "sat_up_255");
        check("sat_255", observed(), {8'd255, 1'b0, 1'b1, 1'b1});
        do_cycle(1, 0, 0, 1, 0, 1, 8'd4, 0, "sat_up_again");
        check("sat_again", observed(), {8'd255, 1'b0, 1'b1, 1'b1});
        do_cycle(1, 0, 0, 1, 0, 1, 8'd0, 0, "step0_at_top");

        // 3: down below zero in both modes
        do_cycle(1, 1, 8'd1, 0, 0, 0, 0, 1, "load1");
        do_cycle(1, 0, 0, 1, 1, 0, 8'd2, 0, "dn_wrap");
        check("dn_wrap_255", observed(), {8'd255, 1'b1, 1'b0, 1'b1});
        do_cycle(1, 1, 8'd1, 0, 0, 0, 0, 0, "load1_b");
        do_cycle(1, 0, 0, 1, 1, 1, 8'd2, 0, "dn_sat");
        check("dn_sat_0", observed(), {8'd0, 1'b0, 1'b1, 1'b1});

        // 4: load beats enable
        do_cycle(1, 1, 8'h40, 1, 0, 0, 8'd2, 0, "load_over_en");
        check("load_40", observed(), {8'h40, 1'b0, 1'b0, 1'b1});
        do_cycle(1, 0, 0, 1, 0, 0, 8'd2, 0, "after_load");
        check("after_load_42", observed(), {8'h42, 1'b0, 1'b0, 1'b1});

        // 5: mid-count reset, then a between-edge glitch
        do_cycle(1, 1, 8'h37, 0, 0, 0, 0, 0, "load37");
        do_cycle(0, 0, 0, 1, 0, 0, 8'd2, 0, "mid_reset");
        check("mid_reset_const", observed(), {8'd1, 1'b0, 1'b0, 1'b0});
        do_cycle(1, 1, 8'h37, 0, 0, 0, 0, 0, "load37_b");
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        hold("glitch_hold");
        check("glitch_const", observed(), {8'h37, 1'b0, 1'b0, 1'b0});

        // 6: sticky clear, and event-beats-clear
        do_cycle(1, 1, 8'hff, 0, 0, 0, 0, 0, "load_ff");
        do_cycle(1, 0, 0, 1, 0, 0, 8'd1, 0, "wrap_to_0");
        do_cycle(1, 0, 0, 0, 0, 0, 0, 1, "clr_alone");
        check("clr_alone_const", observed(), {8'd0, 1'b0, 1'b0, 1'b0});
        do_cycle(1, 1, 8'hff, 0, 0, 0, 0, 0, "load_ff_b");
        do_cycle(1, 0, 0, 1, 0, 0, 8'd1, 1, "wrap_with_clr");
        check("event_beats_clr", observed(), {8'd0, 1'b1, 1'b0, 1'b1});

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
                     W'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 9)),
                     ($urandom_range(0, 5) == 0), "random");
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: observed %0d left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_stride_counter
